// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer and lock supervisor on refclk: drives pll_rst, gates sys_rst on stable lock.
// Optional retry limit with a sticky FAIL state is built when PLL_SUP_RETRY_LIMIT_EN is defined.
module pll_lock_supervisor #(
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT   = 50000,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned MAX_RETRIES    = 4,
  parameter int unsigned CNT_W          = 16
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       locked,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic [2:0] state,
  output logic [7:0] loss_count,
  output logic       fail
);

  typedef enum logic [2:0] {
    StPllRst   = 3'd0,
    StWaitLock = 3'd1,
    StStable   = 3'd2,
    StRun      = 3'd3,
    StFail     = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] RstLoad    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] WaitLoad   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] StableLoad = CNT_W'(STABLE_CYCLES - 1);

  if (PLL_RST_CYCLES < 1 || LOCK_TIMEOUT < 1 || STABLE_CYCLES < 1 || MAX_RETRIES < 1 ||
      CNT_W < 1 || CNT_W > 30 || PLL_RST_CYCLES > (1 << CNT_W) ||
      LOCK_TIMEOUT > (1 << CNT_W) || STABLE_CYCLES > (1 << CNT_W)) begin : g_param_check
    $error("pll_lock_supervisor: invalid parameter set");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       loss_q, loss_d;
  logic             sync1_q, locked_s;
  logic             pll_rst_q, sys_rst_q, ready_q;

  always_ff @(posedge refclk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync1_q  <= locked;
      locked_s <= sync1_q;
    end
  end

`ifdef PLL_SUP_RETRY_LIMIT_EN
  localparam int unsigned RetryW = (MAX_RETRIES > 1) ? $clog2(MAX_RETRIES) : 1;
  logic [RetryW-1:0] retry_q, retry_d;
  logic              retry_last;
  logic              fail_q;

  assign retry_last = (retry_q == RetryW'(MAX_RETRIES - 1));

  always_ff @(posedge refclk) begin
    if (rst) begin
      retry_q <= '0;
      fail_q  <= 1'b0;
    end else begin
      retry_q <= retry_d;
      fail_q  <= (state_d == StFail);
    end
  end

  assign fail = fail_q;
`else
  assign fail = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    loss_d  = loss_q;
`ifdef PLL_SUP_RETRY_LIMIT_EN
    retry_d = retry_q;
`endif
    unique case (state_q)
      StPllRst: begin
        if (cnt_q == '0) begin
          state_d = StWaitLock;
          cnt_d   = WaitLoad;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StWaitLock: begin
        if (locked_s) begin
          state_d = StStable;
          cnt_d   = StableLoad;
        end else if (cnt_q == '0) begin
`ifdef PLL_SUP_RETRY_LIMIT_EN
          if (retry_last) begin
            state_d = StFail;
          end else begin
            state_d = StPllRst;
            cnt_d   = RstLoad;
            retry_d = retry_q + RetryW'(1);
          end
`else
          state_d = StPllRst;
          cnt_d   = RstLoad;
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StStable: begin
        // A lock drop restarts the wait without consuming a retry.
        if (!locked_s) begin
          state_d = StWaitLock;
          cnt_d   = WaitLoad;
        end else if (cnt_q == '0) begin
          state_d = StRun;
`ifdef PLL_SUP_RETRY_LIMIT_EN
          retry_d = '0;
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StRun: begin
        if (!locked_s) begin
          state_d = StPllRst;
          cnt_d   = RstLoad;
          if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
        end
      end
`ifdef PLL_SUP_RETRY_LIMIT_EN
      StFail: begin
        state_d = StFail;
      end
`endif
      default: begin
        state_d = StPllRst;
        cnt_d   = RstLoad;
      end
    endcase
  end

  // Outputs are registered from state_d so they switch on the same edge as state.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q   <= StPllRst;
      cnt_q     <= RstLoad;
      loss_q    <= 8'd0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      loss_q    <= loss_d;
      pll_rst_q <= (state_d == StPllRst) || (state_d == StFail);
      sys_rst_q <= (state_d != StRun);
      ready_q   <= (state_d == StRun);
    end
  end

  assign pll_rst    = pll_rst_q;
  assign sys_rst    = sys_rst_q;
  assign ready      = ready_q;
  assign state      = state_q;
  assign loss_count = loss_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: directed table, hand-timed corner sequences and random locked
// activity, all checked every cycle against a phase/elapsed-time model of the supervisor.
module tb_pll_lock_supervisor;

  localparam int unsigned PRC = 4;
  localparam int unsigned LTO = 20;
  localparam int unsigned STC = 8;
  localparam int unsigned MR  = 2;
`ifdef PLL_SUP_RETRY_LIMIT_EN
  localparam bit LimitEn = 1'b1;
`else
  localparam bit LimitEn = 1'b0;
`endif

  logic       refclk = 1'b0;
  logic       rst;
  logic       locked;
  logic       pll_rst, sys_rst, ready, fail;
  logic [2:0] state;
  logic [7:0] loss_count;

  int n_vec = 0;
  int n_bad = 0;

  // Model: phase 0..4, cycles elapsed in phase, consecutive timeouts, losses, locked history.
  int m_phase, m_age, m_retry, m_loss;
  bit m_s1, m_s2;

  typedef struct {
    bit rst;
    bit locked;
    int n;
    int st;
    bit pll;
    bit sys;
    bit rdy;
  } vec_t;

  vec_t tbl[8];

  pll_lock_supervisor #(
    .PLL_RST_CYCLES(PRC),
    .LOCK_TIMEOUT  (LTO),
    .STABLE_CYCLES (STC),
    .MAX_RETRIES   (MR),
    .CNT_W         (16)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .locked    (locked),
    .pll_rst   (pll_rst),
    .sys_rst   (sys_rst),
    .ready     (ready),
    .state     (state),
    .loss_count(loss_count),
    .fail      (fail)
  );

  always #5 refclk = ~refclk;

  task automatic model_step(input bit r, input bit l);
    bit ls;
    if (r) begin
      m_phase = 0; m_age = 0; m_retry = 0; m_loss = 0; m_s1 = 0; m_s2 = 0;
      return;
    end
    ls = m_s2;
    case (m_phase)
      0: begin
        m_age++;
        if (m_age == PRC) begin m_phase = 1; m_age = 0; end
      end
      1: begin
        if (ls) begin
          m_phase = 2; m_age = 0;
        end else begin
          m_age++;
          if (m_age == LTO) begin
            m_age = 0;
            m_retry++;
            m_phase = (LimitEn && m_retry == MR) ? 4 : 0;
          end
        end
      end
      2: begin
        if (!ls) begin
          m_phase = 1; m_age = 0;
        end else begin
          m_age++;
          if (m_age == STC) begin m_phase = 3; m_age = 0; m_retry = 0; end
        end
      end
      3: begin
        if (!ls) begin
          m_phase = 0; m_age = 0;
          if (m_loss < 255) m_loss++;
        end
      end
      default: ;
    endcase
    m_s2 = m_s1;
    m_s1 = l;
  endtask

  task automatic tick(input bit r, input bit l);
    int e_st;
    bit e_pll, e_sys, e_rdy, e_fail;
    rst    = r;
    locked = l;
    @(posedge refclk);
    model_step(r, l);
    #1;
    e_st   = m_phase;
    e_pll  = (m_phase == 0) || (m_phase == 4);
    e_sys  = (m_phase != 3);
    e_rdy  = (m_phase == 3);
    e_fail = (m_phase == 4);
    n_vec++;
    if (state !== 3'(e_st) || pll_rst !== e_pll || sys_rst !== e_sys || ready !== e_rdy ||
        fail !== e_fail || loss_count !== 8'(m_loss)) begin
      n_bad++;
      $display("FAIL model t=%0t got st=%0d pll=%b sys=%b rdy=%b fail=%b loss=%0d want st=%0d pll=%b sys=%b rdy=%b fail=%b loss=%0d",
               $time, state, pll_rst, sys_rst, ready, fail, loss_count,
               e_st, e_pll, e_sys, e_rdy, e_fail, m_loss);
    end
  endtask

  task automatic check(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic wait_ready(input string name, input int budget);
    for (int i = 0; i < budget && ready !== 1'b1; i++) tick(1'b0, 1'b1);
    check(name, int'(ready === 1'b1), 1);
  endtask

  task automatic glitch();
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
  endtask

  initial begin
    int prev_loss;
    rst    = 1'b1;
    locked = 1'b0;

    // rst, locked, cycles, then expected state/pll_rst/sys_rst/ready after the last cycle.
    tbl[0] = '{1'b1, 1'b1, 2, 0, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 3, 0, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1, 1, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1, 2, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 7, 2, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 1, 3, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 1'b1, 5, 3, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{1'b1, 1'b1, 1, 0, 1'b1, 1'b1, 1'b0};

    for (int v = 0; v < 8; v++) begin
      repeat (tbl[v].n) tick(tbl[v].rst, tbl[v].locked);
      check($sformatf("tbl%0d.state", v), int'(state), tbl[v].st);
      check($sformatf("tbl%0d.pll_rst", v), int'(pll_rst), int'(tbl[v].pll));
      check($sformatf("tbl%0d.sys_rst", v), int'(sys_rst), int'(tbl[v].sys));
      check($sformatf("tbl%0d.ready", v), int'(ready), int'(tbl[v].rdy));
    end
    check("tbl.loss_after_rst", int'(loss_count), 0);

    // Lock never arrives: timeout re-pulses pll_rst every PRC+LTO cycles.
    repeat (2) tick(1'b1, 1'b0);
    repeat (PRC + LTO - 1) tick(1'b0, 1'b0);
    check("nolock.wait_state", int'(state), 1);
    check("nolock.wait_pll", int'(pll_rst), 0);
    tick(1'b0, 1'b0);
    check("nolock.retry1_state", int'(state), 0);
    check("nolock.retry1_pll", int'(pll_rst), 1);
    repeat (PRC + LTO) tick(1'b0, 1'b0);
`ifdef PLL_SUP_RETRY_LIMIT_EN
    check("nolock.fail_state", int'(state), 4);
    check("nolock.fail_flag", int'(fail), 1);
    repeat (10) tick(1'b0, 1'b1);
    check("nolock.fail_sticky", int'(state), 4);
    check("nolock.fail_pll", int'(pll_rst), 1);
`else
    check("nolock.retry2_state", int'(state), 0);
    check("nolock.retry2_pll", int'(pll_rst), 1);
    check("nolock.fail_tied", int'(fail), 0);
`endif
    tick(1'b1, 1'b1);
    check("nolock.rst_state", int'(state), 0);
    check("nolock.rst_fail", int'(fail), 0);

    // Lock drop with STABLE counter at 3 restarts the stable window.
    tick(1'b1, 1'b1);
    repeat (PRC + 1 + 4) tick(1'b0, 1'b1);
    check("stable.in_stable", int'(state), 2);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    check("stable.back_to_wait", int'(state), 1);
    repeat (STC) tick(1'b0, 1'b1);
    check("stable.no_early_run", int'(state), 2);
    tick(1'b0, 1'b1);
    check("stable.run", int'(state), 3);
    check("stable.loss", int'(loss_count), 0);

    // One-cycle glitch in RUN: sys_rst rises on the third edge.
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    check("glitch.sys_held", int'(sys_rst), 0);
    tick(1'b0, 1'b1);
    check("glitch.sys_rst", int'(sys_rst), 1);
    check("glitch.ready", int'(ready), 0);
    check("glitch.loss", int'(loss_count), 1);
    wait_ready("glitch.rerun", 40);

    // 256 further losses: counter must saturate, not wrap.
    for (int k = 0; k < 256; k++) begin
      glitch();
      wait_ready("sat.rerun", 40);
    end
    check("sat.loss", int'(loss_count), 255);
    glitch();
    check("sat.loss_hold", int'(loss_count), 255);

    // rst while RUN clears everything on the next edge.
    wait_ready("rst_run.rerun", 40);
    prev_loss = int'(loss_count);
    check("rst_run.pre_loss", prev_loss, 255);
    tick(1'b1, 1'b1);
    check("rst_run.state", int'(state), 0);
    check("rst_run.loss", int'(loss_count), 0);

    // Random locked activity with occasional resets.
    tick(1'b0, 1'b1);
    for (int run = 0; run < 150; run++) begin
      bit l;
      int len;
      l   = ($urandom_range(0, 3) != 0);
      len = $urandom_range(1, 40);
      for (int c = 0; c < len; c++) tick(($urandom_range(0, 499) == 0), l);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
